// File: rtl/decode_stage_pkg.sv
// Shared instruction-set definitions for the decode stage: opcode constants
// and the opcode classification helpers used by decode, hazard detection
// and the verification model.
package decode_stage_pkg;

  localparam int unsigned OP_W = 6;

  // Opcode constants (command[31:26]).
  localparam logic [OP_W-1:0] INST_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] INST_J    = 6'b000010;
  localparam logic [OP_W-1:0] INST_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] INST_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] INST_FADD = 6'b011000;
  localparam logic [OP_W-1:0] INST_LW   = 6'b100011;
  localparam logic [OP_W-1:0] INST_FLW  = 6'b100111;
  localparam logic [OP_W-1:0] INST_SW   = 6'b101011;

  // Branches compare two registers, so their second source sits in [25:21].
  function automatic logic is_branch_inst(input logic [OP_W-1:0] op);
    return (op == INST_BEQ) || (op == INST_BNE);
  endfunction

  // Loads produce their result late; a dependent reader must wait one cycle.
  function automatic logic is_load_inst(input logic [OP_W-1:0] op);
    return (op == INST_LW) || (op == INST_FLW);
  endfunction

  // Destination register lives in the floating-point file.
  function automatic logic dst_is_fp(input logic [OP_W-1:0] op);
    return (op == INST_FLW) || (op == INST_FADD);
  endfunction

  // Destination register number: R-format (command[29:26]==0) uses [15:11],
  // every other format uses [25:21].
  function automatic logic [4:0] dst_field(input logic [31:0] command);
    return (command[29:26] == 4'b0000) ? command[15:11] : command[25:21];
  endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// Purely combinational field extraction for one instruction word: register
// read addresses, register-file selects and destination-file flag.
// Field positions are fixed for a 5-bit register number.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [31:0]      command,
  output logic [REG_W-1:0] reg1,
  output logic [REG_W-1:0] reg2,
  output logic             fmode1,
  output logic             fmode2,
  output logic             dst_fp
);

  logic [OP_W-1:0] opcode;

  assign opcode = command[31:26];

  // Decode read addresses and file selects from the instruction word.
  always_comb begin
    reg1 = command[20:16];
    if ((command[29:26] == 4'b0000) || is_branch_inst(opcode)) begin
      reg2 = command[25:21];
    end else begin
      reg2 = command[15:11];
    end
    fmode1 = command[30] & (command[29:27] != 3'b000);
    fmode2 = command[30] & (command[29:26] == 4'b0001);
    dst_fp = dst_is_fp(opcode);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage between fetch and execute. Drives the register-file
// read ports combinationally and captures the decoded instruction plus its
// operands into a one-entry output register with valid/ready handshake,
// synchronous flush and a load-use interlock that inserts one bubble.
// Optional write-back bypass: define DECODE_BYPASS_EN. Without it the wb_*
// inputs are ignored and the register file must be write-first.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PC_W         = 32,
  parameter int REG_W        = 5,
  parameter bit HAZARD_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [31:0]      in_command,
  input  logic             flush,
  output logic [REG_W-1:0] reg1,
  output logic [REG_W-1:0] reg2,
  output logic             fmode1,
  output logic             fmode2,
  input  logic [XLEN-1:0]  reg_out1,
  input  logic [XLEN-1:0]  reg_out2,
  input  logic             wb_en,
  input  logic             wb_fmode,
  input  logic [REG_W-1:0] wb_no,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       opecode,
  output logic [15:0]      offset,
  output logic [PC_W-1:0]  pc_out,
  output logic [XLEN-1:0]  rs,
  output logic [XLEN-1:0]  rt,
  output logic [REG_W-1:0] rd_no,
  output logic [REG_W-1:0] rs_no,
  output logic [REG_W-1:0] rt_no,
  output logic             fmode1_reg,
  output logic             fmode2_reg,
  output logic             dst_fp
);

  logic             dst_fp_in;
  logic [REG_W-1:0] rd_in;
  logic             match1;
  logic             match2;
  logic             hazard;
  logic             load_en;
  logic [XLEN-1:0]  rs_next;
  logic [XLEN-1:0]  rt_next;

  decode_fields #(
    .REG_W (REG_W)
  ) u_fields (
    .command (in_command),
    .reg1    (reg1),
    .reg2    (reg2),
    .fmode1  (fmode1),
    .fmode2  (fmode2),
    .dst_fp  (dst_fp_in)
  );

  assign rd_in = REG_W'(dst_field(in_command));

  // Load-use detection against the held instruction; integer r0 never matches.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    match1 = 1'b0;
    match2 = 1'b0;
    if ((reg1 == rd_no) && (fmode1 == dst_fp) && !((reg1 == '0) && !fmode1)) begin
      match1 = 1'b1;
    end
    if ((reg2 == rd_no) && (fmode2 == dst_fp) && !((reg2 == '0) && !fmode2)) begin
      match2 = 1'b1;
    end
    hazard = HAZARD_CHECK && out_valid && is_load_inst(opecode) && (match1 || match2);
  end

  assign in_ready = flush | ((~out_valid | out_ready) & ~hazard);
  assign load_en  = in_valid & in_ready & ~flush;

  // Operand selection: register-file data, optionally overridden by write-back.
  always_comb begin
    rs_next = reg_out1;
    rt_next = reg_out2;
`ifdef DECODE_BYPASS_EN
    if (wb_en && (wb_no == reg1) && (wb_fmode == fmode1) && !((wb_no == '0) && !wb_fmode)) begin
      rs_next = wb_data;
    end
    if (wb_en && (wb_no == reg2) && (wb_fmode == fmode2) && !((wb_no == '0) && !wb_fmode)) begin
      rt_next = wb_data;
    end
`endif
  end

`ifndef DECODE_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_fmode, wb_no, wb_data};
`endif

  // Output valid flag: flush, accept, drain/bubble, or hold, in that priority.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rstn) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
    end else if (out_ready && out_valid && (!in_valid || hazard)) begin
      out_valid <= 1'b0;
    end
  end

  // Payload register: loaded only on acceptance, otherwise held stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opecode    <= INST_J;
      offset     <= '0;
      pc_out     <= '0;
      rs         <= '0;
      rt         <= '0;
      rd_no      <= '0;
      rs_no      <= '0;
      rt_no      <= '0;
      fmode1_reg <= 1'b0;
      fmode2_reg <= 1'b0;
      dst_fp     <= 1'b0;
    end else if (load_en) begin
      opecode    <= in_command[31:26];
      offset     <= in_command[15:0];
      pc_out     <= in_pc;
      rs         <= rs_next;
      rt         <= rt_next;
      rd_no      <= rd_in;
      rs_no      <= reg1;
      rt_no      <= reg2;
      fmode1_reg <= fmode1;
      fmode2_reg <= fmode2;
      dst_fp     <= dst_fp_in;
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised decode pipeline stage for the core. It sits between fetch and execute.
- Extracts instruction fields, drives the register-file read ports and captures operands into a one-entry output register.
- Adds a valid/ready handshake, synchronous flush, load-use interlock (bubble insertion) and an optional write-back bypass.

Parameters:
- XLEN, 32, operand/data width.
- PC_W, 32, program counter width.
- REG_W, 5, register number width; command field positions are fixed for REG_W=5.
- HAZARD_CHECK, 1, 1 = load-use interlock enabled, 0 = never stall for hazards.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  PC_W  instruction PC
- in_command  in  32  instruction word
- flush  in  1  kill the held instruction and the incoming instruction
- reg1, reg2  out  REG_W  register-file read addresses (combinational)
- fmode1, fmode2  out  1  FP-file select for each read port (combinational)
- reg_out1, reg_out2  in  XLEN  register-file read data (same cycle)
- wb_en  in  1  write-back strobe (used only with bypass)
- wb_fmode  in  1  write-back target file
- wb_no  in  REG_W  write-back register
- wb_data  in  XLEN  write-back data
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- opecode  out  6  command[31:26]
- offset  out  16  command[15:0]
- pc_out  out  PC_W  PC
- rs, rt  out  XLEN  operands
- rd_no, rs_no, rt_no  out  REG_W  register numbers
- fmode1_reg, fmode2_reg  out  1  registered fmode bits
- dst_fp  out  1  destination register is in the FP file

Behaviour:
- Combinational field extraction:
  - reg1 = command[20:16].
  - reg2 = command[25:21] if command[29:26]==0 or is_branch_inst(opcode); otherwise command[15:11].
  - fmode1 = command[30] & (command[29:27]!=0).
  - fmode2 = command[30] & (command[29:26]==4'b0001).
  - dst_fp comes from package function dst_is_fp(opcode).
- Reset (async, rstn low): out_valid=0, opecode=INST_J, all other registered outputs 0. Reset mid-transfer discards everything.
- hazard = HAZARD_CHECK & out_valid & is_load_inst(opecode) & ((reg1==rd_no & fmode1==dst_fp) | (reg2==rd_no & fmode2==dst_fp)). Register 0 of the integer file never matches.
- in_ready = flush | ((~out_valid | out_ready) & ~hazard).
- Per cycle, in priority order:
  1. flush: out_valid<=0; the input is consumed and dropped; payload registers hold their values.
  2. in_valid & in_ready: load all payload registers from the current command and register data; out_valid<=1. Latency is 1 cycle from acceptance to out_valid.
  3. out_ready & out_valid & (~in_valid | hazard): out_valid<=0. A hazard therefore yields exactly one bubble cycle.
  4. Otherwise hold all registers.
- Payload must stay stable while out_valid & ~out_ready.
- Back-to-back throughput is 1/cycle with no hazard.
- Operand width is XLEN and is copied without extension. offset is raw; sign-extension is done in execute.

Optional Feature:
- DECODE_BYPASS_EN defined:
  - At capture, if wb_en & wb_no==reg1 & wb_fmode==fmode1, rs takes wb_data instead of reg_out1. The same rule applies to rt/reg2.
  - Integer register 0 is never bypassed.
- DECODE_BYPASS_EN undefined: wb_* ports are present but ignored; the register file must be write-first.

Decomposition:
- The shared instruction-set package holds the opcode constants (INST_J, INST_LW, INST_FLW, branch opcodes) plus is_branch_inst, is_load_inst and dst_is_fp.
- Sub-module decode_fields: purely combinational extraction of reg1, reg2, fmode1, fmode2 and dst_fp from the command. It is reused by the hazard logic and by the verification model.

Test Plan:
- Reset: assert rstn=0 mid-stream -> out_valid=0, opecode=INST_J, pc_out=0 immediately (asynchronous).
- Throughput: 4 ALU instructions at PCs 0x0,0x4,0x8,0xC with out_ready=1 -> out_valid continuous. pc_out follows one cycle later, rs/rt equal the register-model values.
- Backpressure: out_ready=0 for 3 cycles with an instruction held -> all outputs stable, in_ready=0. Release -> next instruction appears on the following cycle.
- Load-use: INST_LW writing rd=5, then ADD reading reg1=5 -> exactly one bubble (out_valid=0 for one cycle), ADD issued next. Repeat with INST_FLW against an integer reader -> no bubble.
- Flush: flush with a held instruction and in_valid=1 -> next cycle out_valid=0, the incoming instruction never appears, in_ready=1 during flush.
- Bypass (DECODE_BYPASS_EN): wb_en=1, wb_no=7, wb_data=0xDEADBEEF while decoding reg1=7 -> rs=0xDEADBEEF. With wb_no=0 (integer file) -> rs=reg_out1.
